logic_shift_unit: RTL



---
 rtl/logic_unit_pkg.sv | 23 ++
 rtl/logic_shift_core.sv | 58 +++++
 rtl/logic_shift_unit.sv | 116 +++++++++++
 3 files changed

// File: rtl/logic_unit_pkg.sv
// rtl/logic_unit_pkg.sv - opcode encodings and opcode legality helper for logic_shift_unit
package logic_unit_pkg;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_NAND = 4'b0010;
    localparam logic [3:0] OP_NOR  = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_XNOR = 4'b0101;
    localparam logic [3:0] OP_NOT  = 4'b0110;
    localparam logic [3:0] OP_PASS = 4'b0111;
    localparam logic [3:0] OP_SHL  = 4'b1000;
    localparam logic [3:0] OP_SHR  = 4'b1001;
    localparam logic [3:0] OP_ASR  = 4'b1010;
    localparam logic [3:0] OP_ROL  = 4'b1011;
    localparam logic [3:0] OP_ROR  = 4'b1100;

    // Encodings above OP_ROR are reserved and flagged as errors.
    function automatic logic is_legal_op(input logic [3:0] op);
        return (op <= OP_ROR);
    endfunction

endpackage

// File: rtl/logic_shift_core.sv
// rtl/logic_shift_core.sv - combinational logic/shift/rotate datapath
//
// Ports:
//   a_i, b_i   operands (shifts use only b_i[SHW-1:0] as the amount)
//   op_i       4-bit opcode
//   res_o      2*WIDTH result; upper half zero except SHL spill and ASR sign fill
//   err_o      opcode is illegal (res_o forced to zero)
module logic_shift_core
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    input  logic [3:0]         op_i,
    output logic [2*WIDTH-1:0] res_o,
    output logic               err_o
);

    localparam int SHW = $clog2(WIDTH);

    logic [SHW-1:0]     sh;
    logic [2*WIDTH-1:0] shl_t;
    logic [2*WIDTH-1:0] asr_t;
    logic [2*WIDTH-1:0] rol_t;
    logic [2*WIDTH-1:0] ror_t;

    assign sh = b_i[SHW-1:0];

    // Rotates are done by shifting a doubled copy of A: the wrapped bits
    // fall naturally into the half we keep.
    assign shl_t = {{WIDTH{1'b0}}, a_i} << sh;
    assign asr_t = $signed({{WIDTH{a_i[WIDTH-1]}}, a_i}) >>> sh;
    assign rol_t = {a_i, a_i} << sh;
    assign ror_t = {a_i, a_i} >> sh;

    always_comb begin
        res_o = '0;
        err_o = !is_legal_op(op_i);
        case (op_i)
            OP_AND:  res_o = {{WIDTH{1'b0}}, a_i & b_i};
            OP_OR:   res_o = {{WIDTH{1'b0}}, a_i | b_i};
            OP_NAND: res_o = {{WIDTH{1'b0}}, ~(a_i & b_i)};
            OP_NOR:  res_o = {{WIDTH{1'b0}}, ~(a_i | b_i)};
            OP_XOR:  res_o = {{WIDTH{1'b0}}, a_i ^ b_i};
            OP_XNOR: res_o = {{WIDTH{1'b0}}, ~(a_i ^ b_i)};
            OP_NOT:  res_o = {{WIDTH{1'b0}}, ~a_i};
            OP_PASS: res_o = {{WIDTH{1'b0}}, a_i};
            OP_SHL:  res_o = shl_t;
            OP_SHR:  res_o = {{WIDTH{1'b0}}, a_i >> sh};
            OP_ASR:  res_o = asr_t;
            OP_ROL:  res_o = {{WIDTH{1'b0}}, rol_t[2*WIDTH-1:WIDTH]};
            OP_ROR:  res_o = {{WIDTH{1'b0}}, ror_t[WIDTH-1:0]};
            default: res_o = '0;
        endcase
    end

endmodule

// File: rtl/logic_shift_unit.sv
// rtl/logic_shift_unit.sv - two-stage valid/ready pipelined logic and shift unit
//
// Ports:
//   clk, RST               clock, synchronous active-high reset
//   A, B, ALU_FUN          request operands and opcode
//   In_Valid / In_Ready    request handshake (In_Ready follows Out_Ready combinationally)
//   Logic_OUT              2*WIDTH result
//   Logic_Flag / Out_Ready result handshake
//   Zero_Flag, Err_Flag    result is zero / opcode illegal, qualified by Logic_Flag
module logic_shift_unit
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               RST,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic [3:0]         ALU_FUN,
    input  logic               In_Valid,
    output logic               In_Ready,
    output logic [2*WIDTH-1:0] Logic_OUT,
    output logic               Logic_Flag,
    input  logic               Out_Ready,
    output logic               Zero_Flag,
    output logic               Err_Flag
);

    // Stage 1: captured request
    logic               s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [3:0]         op_q, op_d;

    // Stage 2: registered result
    logic               out_valid_q, out_valid_d;
    logic [2*WIDTH-1:0] res_q, res_d;
    logic               zero_q, zero_d;
    logic               err_q, err_d;

    logic               out_adv;
    logic               accept;
    logic [2*WIDTH-1:0] core_res;
    logic               core_err;

    logic_shift_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a_i   (a_q),
        .b_i   (b_q),
        .op_i  (op_q),
        .res_o (core_res),
        .err_o (core_err)
    );

    // Output stage can take new data when empty or being drained this cycle.
    assign out_adv  = !out_valid_q || Out_Ready;
    assign In_Ready = !s1_valid_q || out_adv;
    assign accept   = In_Valid && In_Ready;

    always_comb begin
        s1_valid_d  = s1_valid_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        out_valid_d = out_valid_q;
        res_d       = res_q;
        zero_d      = zero_q;
        err_d       = err_q;

        if (accept) begin
            a_d  = A;
            b_d  = B;
            op_d = ALU_FUN;
        end
        // s1 stays full only if it held data that could not move forward.
        s1_valid_d = accept || (s1_valid_q && !out_adv);

        if (out_adv) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                res_d  = core_res;
                zero_d = (core_res == '0);
                err_d  = core_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            s1_valid_q  <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            out_valid_q <= 1'b0;
            res_q       <= '0;
            zero_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            out_valid_q <= out_valid_d;
            res_q       <= res_d;
            zero_q      <= zero_d;
            err_q       <= err_d;
        end
    end

    assign Logic_OUT  = res_q;
    assign Logic_Flag = out_valid_q;
    assign Zero_Flag  = zero_q;
    assign Err_Flag   = err_q;

endmodule
